// File: rtl/life_pkg.sv
// Shared grid geometry, FSM state encoding and cell addressing for the
// Game of Life step engine.
package life_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 16;
    localparam int CELLS  = GRID_W * GRID_H;
    localparam int ROW_W  = $clog2(GRID_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cell_idx(input int r, input int c);
        return r * GRID_W + c;
    endfunction

endpackage

// File: rtl/life_row_rule.sv
// Combinational Life rule for one 16-cell row given the rows above and below.
// Column edges are padded with zero or with the opposite column when WRAP=1.
module life_row_rule
    import life_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic [GRID_W-1:0] above,
    input  logic [GRID_W-1:0] mid,
    input  logic [GRID_W-1:0] below,
    output logic [GRID_W-1:0] row_next
);

    // ext[0] is the cell left of column 0, ext[GRID_W+1] the cell right of column 15
    function automatic logic [GRID_W+1:0] pad(input logic [GRID_W-1:0] r);
        return {(WRAP ? r[0] : 1'b0), r, (WRAP ? r[GRID_W-1] : 1'b0)};
    endfunction

    logic [GRID_W+1:0] ea;
    logic [GRID_W+1:0] em;
    logic [GRID_W+1:0] eb;
    logic [3:0]        cnt;

    always_comb begin
        ea       = pad(above);
        em       = pad(mid);
        eb       = pad(below);
        row_next = '0;
        cnt      = '0;
        for (int c = 0; c < GRID_W; c++) begin
            cnt = 4'(ea[c]) + 4'(ea[c+1]) + 4'(ea[c+2])
                + 4'(em[c])               + 4'(em[c+2])
                + 4'(eb[c]) + 4'(eb[c+1]) + 4'(eb[c+2]);
            row_next[c] = (cnt == 4'd3) || (mid[c] && (cnt == 4'd2));
        end
    end

endmodule

// File: rtl/life_step.sv
// One Game of Life generation on a 16x16 grid, computed a row per cycle
// from a captured snapshot; the finished grid is published in one update.
//
//   state | meaning
//   IDLE  | waiting for start; next holds the last published generation
//   RUN   | computing row `row` of the snapshot into the work buffer
//   DONE  | work buffer complete; publish it to next on the following edge
module life_step
    import life_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CELLS-1:0] cur,
    output logic [CELLS-1:0] next,
    output logic             busy,
    output logic             done,
    output logic [15:0]      gen
);

    state_t            state;
    state_t            state_nxt;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  row_up;
    logic [ROW_W-1:0]  row_dn;
    logic [CELLS-1:0]  snap;
    logic [CELLS-1:0]  work;
    logic [GRID_W-1:0] row_above;
    logic [GRID_W-1:0] row_mid;
    logic [GRID_W-1:0] row_below;
    logic [GRID_W-1:0] row_new;
    logic              capture;
    logic              row_wr;
    logic              load_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (row == ROW_W'(GRID_H - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture   = (state == IDLE) && start;
        row_wr    = (state == RUN);
        load_next = (state == DONE);
        busy      = (state == RUN);
    end

    // Row indices wrap naturally in ROW_W bits; the edge rows are zeroed unless WRAP
    assign row_up = row - ROW_W'(1);
    assign row_dn = row + ROW_W'(1);

    always_comb begin
        row_mid   = snap[cell_idx(int'(row), 0) +: GRID_W];
        row_above = snap[cell_idx(int'(row_up), 0) +: GRID_W];
        row_below = snap[cell_idx(int'(row_dn), 0) +: GRID_W];
        if (!WRAP && (row == '0))                    row_above = '0;
        if (!WRAP && (row == ROW_W'(GRID_H - 1)))    row_below = '0;
    end

    life_row_rule #(.WRAP(WRAP)) u_rule (
        .above    (row_above),
        .mid      (row_mid),
        .below    (row_below),
        .row_next (row_new)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= '0;
            snap <= '0;
            work <= '0;
            next <= '0;
            done <= 1'b0;
            gen  <= '0;
        end else begin
            done <= load_next;
            if (capture) begin
                snap <= cur;
                row  <= '0;
            end
            if (row_wr) begin
                work[cell_idx(int'(row), 0) +: GRID_W] <= row_new;
                row <= row + ROW_W'(1);
            end
            if (load_next) begin
                next <= work;
                gen  <= gen + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_life_step.sv
// Directed bench for life_step: a table of grids checked against hand-derived
// next generations for both edge modes, plus control and reset sequences.
module tb_life_step;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] cur;
    logic [255:0] next0, next1;
    logic         busy0, busy1;
    logic         done0, done1;
    logic [15:0]  gen0, gen1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    life_step #(.WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .cur(cur),
        .next(next0), .busy(busy0), .done(done0), .gen(gen0)
    );

    life_step #(.WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .cur(cur),
        .next(next1), .busy(busy1), .done(done1), .gen(gen1)
    );

    typedef struct {
        logic [255:0] grid;
        logic [255:0] exp0;
        logic [255:0] exp1;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [255:0] cells(input int a, input int b, input int c, input int d);
        logic [255:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Start one step on grid g; lat = edges after the start edge until done is seen
    task automatic run_step(input logic [255:0] g, output int lat,
                            output logic b1, output logic b15, output logic b16);
        @(negedge clk);
        cur   = g;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        b1 = 1'b0; b15 = 1'b0; b16 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1)  b1  = busy0;
            if (k == 15) b15 = busy0;
            if (k == 16) b16 = busy0;
            if (done0) begin
                lat = k;
                break;
            end
        end
    endtask

    int           lat;
    logic         b1, b15, b16;
    int           exp_gen;
    int           n_done;
    logic [255:0] ones;
    logic [255:0] blink_h, blink_v;

    initial begin
        ones    = '1;
        blink_h = cells(84, 85, 86, -1);
        blink_v = cells(69, 85, 101, -1);

        vecs[0] = '{blink_h, blink_v, blink_v};
        vecs[1] = '{blink_v, blink_h, blink_h};
        vecs[2] = '{cells(0, 1, 16, 17), cells(0, 1, 16, 17), cells(0, 1, 16, 17)};
        vecs[3] = '{ones, cells(0, 15, 240, 255), '0};
        vecs[4] = '{cells(0, 15, 240, -1), '0, cells(0, 15, 240, 255)};
        vecs[5] = '{'0, '0, '0};
        vecs[6] = '{cells(120, -1, -1, -1), '0, '0};
        vecs[7] = '{cells(0, 1, 16, -1), cells(0, 1, 16, 17), cells(0, 1, 16, 17)};

        rst   = 1'b1;
        start = 1'b0;
        cur   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_next0", next0, '0);
        chk("reset_next1", next1, '0);
        chk("reset_busy", {255'd0, busy0}, '0);
        chk("reset_done", {255'd0, done0}, '0);
        chk("reset_gen", {240'd0, gen0}, '0);
        @(negedge clk);
        rst = 1'b0;

        exp_gen = 0;
        for (int i = 0; i < 8; i++) begin
            run_step(vecs[i].grid, lat, b1, b15, b16);
            exp_gen++;
            chk($sformatf("v%0d_latency", i), 256'(lat), 256'(17));
            chk($sformatf("v%0d_busy_first", i), {255'd0, b1}, 256'(1));
            chk($sformatf("v%0d_busy_last", i), {255'd0, b15}, 256'(1));
            chk($sformatf("v%0d_busy_done", i), {255'd0, b16}, '0);
            chk($sformatf("v%0d_next_w0", i), next0, vecs[i].exp0);
            chk($sformatf("v%0d_next_w1", i), next1, vecs[i].exp1);
            chk($sformatf("v%0d_done_w1", i), {255'd0, done1}, 256'(1));
            chk($sformatf("v%0d_gen", i), {240'd0, gen0}, 256'(exp_gen));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), {255'd0, done0}, '0);
            chk($sformatf("v%0d_next_hold", i), next0, vecs[i].exp0);
        end

        // Blinker fed back from its own result, then the control sequence
        rst = 1'b1;
        #1;
        chk("rst_gen", {240'd0, gen0}, '0);
        @(negedge clk);
        rst = 1'b0;
        exp_gen = 0;
        run_step(blink_h, lat, b1, b15, b16);
        chk("blink1_next", next0, blink_v);
        chk("blink1_gen", {240'd0, gen0}, 256'(1));
        run_step(next0, lat, b1, b15, b16);
        chk("blink2_next", next0, blink_h);
        chk("blink2_gen", {240'd0, gen0}, 256'(2));

        // cur changed at +3 and a stray start at +5 must not affect the step
        @(negedge clk);
        cur   = blink_h;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) cur = ones;
            if (k == 4) begin
                start = 1'b1;
                chk("ctl_busy_at_start", {255'd0, busy0}, 256'(1));
            end
            if (k == 5) start = 1'b0;
            if (done0) begin
                lat = k;
                break;
            end
        end
        chk("ctl_latency", 256'(lat), 256'(17));
        chk("ctl_next_captured", next0, blink_v);
        chk("ctl_gen", {240'd0, gen0}, 256'(3));
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done0) n_done++;
        end
        chk("ctl_single_done", 256'(n_done), '0);
        chk("ctl_gen_after", {240'd0, gen0}, 256'(3));
        chk("ctl_idle_busy", {255'd0, busy0}, '0);

        // Reset in the middle of a step
        @(negedge clk);
        cur   = blink_h;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_next", next0, '0);
        chk("midrst_busy", {255'd0, busy0}, '0);
        chk("midrst_gen", {240'd0, gen0}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) n_done++;
        end
        chk("midrst_no_done", 256'(n_done), '0);
        run_step(blink_v, lat, b1, b15, b16);
        chk("midrst_latency", 256'(lat), 256'(17));
        chk("midrst_next_after", next0, blink_h);
        chk("midrst_gen_after", {240'd0, gen0}, 256'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
